// File: rtl/dma_memcpy_ctrl.sv
// Host-to-host memcpy sequencer: splits a copy into DMA chunks and loops each line
// from the DMA read FIFO straight into the DMA write port.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for go
// S_LAUNCH | pulse rd_go/wr_go for the current chunk
// S_ARM    | one settling cycle; DMA done flags are not trusted yet
// S_XFER   | move lines FIFO -> write port until chunk_left reaches 0
// S_DRAIN  | wait for both DMA sides idle, then advance to the next chunk
// S_DONE   | one-cycle done pulse
module dma_memcpy_ctrl #(
  parameter int ADDR_WIDTH      = 42,
  parameter int DATA_WIDTH      = 512,
  parameter int CHUNK_LINES     = 256,
  parameter int CYCLE_CNT_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  input  logic [ADDR_WIDTH-1:0]      src_addr,
  input  logic [ADDR_WIDTH-1:0]      dst_addr,
  input  logic [ADDR_WIDTH:0]        size,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                chunks_issued,
  output logic [CYCLE_CNT_WIDTH-1:0] cycle_count,
  output logic                       dma_rd_go,
  output logic                       dma_wr_go,
  output logic [ADDR_WIDTH-1:0]      dma_rd_addr,
  output logic [ADDR_WIDTH-1:0]      dma_wr_addr,
  output logic [ADDR_WIDTH:0]        dma_size,
  output logic                       dma_rd_en,
  input  logic [DATA_WIDTH-1:0]      dma_rd_data,
  input  logic                       dma_empty,
  output logic                       dma_wr_en,
  output logic [DATA_WIDTH-1:0]      dma_wr_data,
  input  logic                       dma_full,
  input  logic                       dma_rd_done,
  input  logic                       dma_wr_done
);

  localparam logic [ADDR_WIDTH:0] CHUNK = (ADDR_WIDTH+1)'(CHUNK_LINES);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_ARM, S_XFER, S_DRAIN, S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      cur_src_q, cur_src_d;
  logic [ADDR_WIDTH-1:0]      cur_dst_q, cur_dst_d;
  logic [ADDR_WIDTH:0]        total_left_q, total_left_d;
  logic [ADDR_WIDTH:0]        chunk_q, chunk_d;
  logic [ADDR_WIDTH:0]        chunk_left_q, chunk_left_d;
  logic [15:0]                chunks_issued_q, chunks_issued_d;
  logic [CYCLE_CNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
  logic                       xfer;
  logic [ADDR_WIDTH:0]        left_after;

  function automatic logic [ADDR_WIDTH:0] chunk_of(input logic [ADDR_WIDTH:0] n);
    return (n < CHUNK) ? n : CHUNK;
  endfunction

  always_comb begin
    state_d         = state_q;
    cur_src_d       = cur_src_q;
    cur_dst_d       = cur_dst_q;
    total_left_d    = total_left_q;
    chunk_d         = chunk_q;
    chunk_left_d    = chunk_left_q;
    chunks_issued_d = chunks_issued_q;
    cycle_count_d   = cycle_count_q;
    xfer       = (state_q == S_XFER) && !dma_empty && !dma_full && (chunk_left_q != '0);
    left_after = total_left_q - chunk_q;

    if (busy && (cycle_count_q != '1))
      cycle_count_d = cycle_count_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          chunks_issued_d = '0;
          cycle_count_d   = '0;
          if (size == '0) begin
            state_d = S_DONE;
          end else begin
            cur_src_d    = src_addr;
            cur_dst_d    = dst_addr;
            total_left_d = size;
            chunk_d      = chunk_of(size);
            state_d      = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        chunk_left_d = chunk_q;
        if (chunks_issued_q != '1)
          chunks_issued_d = chunks_issued_q + 16'd1;
        state_d = S_ARM;
      end
      S_ARM: state_d = S_XFER;
      S_XFER: begin
        if (xfer)
          chunk_left_d = chunk_left_q - 1'b1;
        if ((chunk_left_q == '0) || (xfer && (chunk_left_q == (ADDR_WIDTH+1)'(1))))
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (dma_rd_done && dma_wr_done) begin
          total_left_d = left_after;
          // Chunk outputs only move on the way into the next launch so they hold after the last one.
          if (left_after == '0) begin
            state_d = S_DONE;
          end else begin
            cur_src_d = cur_src_q + chunk_q[ADDR_WIDTH-1:0];
            cur_dst_d = cur_dst_q + chunk_q[ADDR_WIDTH-1:0];
            chunk_d   = chunk_of(left_after);
            state_d   = S_LAUNCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cur_src_q       <= '0;
      cur_dst_q       <= '0;
      total_left_q    <= '0;
      chunk_q         <= '0;
      chunk_left_q    <= '0;
      chunks_issued_q <= '0;
      cycle_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      cur_src_q       <= cur_src_d;
      cur_dst_q       <= cur_dst_d;
      total_left_q    <= total_left_d;
      chunk_q         <= chunk_d;
      chunk_left_q    <= chunk_left_d;
      chunks_issued_q <= chunks_issued_d;
      cycle_count_q   <= cycle_count_d;
    end
  end

  assign busy          = (state_q == S_LAUNCH) || (state_q == S_ARM) ||
                         (state_q == S_XFER)   || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign chunks_issued = chunks_issued_q;
  assign cycle_count   = cycle_count_q;
  assign dma_rd_go     = (state_q == S_LAUNCH);
  assign dma_wr_go     = (state_q == S_LAUNCH);
  assign dma_rd_addr   = cur_src_q;
  assign dma_wr_addr   = cur_dst_q;
  assign dma_size      = chunk_q;
  assign dma_rd_en     = xfer;
  assign dma_wr_en     = xfer;
  assign dma_wr_data   = xfer ? dma_rd_data : '0;

endmodule
